// File: rtl/envelope_pkg.sv
// Shared envelope definitions: state encodings and saturating arithmetic helpers.
// ENVELOPE_EXP_RELEASE_EN (see envelope_level_gen) does not alter anything here.
package envelope_pkg;

   typedef enum logic [2:0] {
      ENV_IDLE    = 3'd0,
      ENV_ATTACK  = 3'd1,
      ENV_DECAY   = 3'd2,
      ENV_SUSTAIN = 3'd3,
      ENV_RELEASE = 3'd4
   } env_state_e;

   localparam logic [2:0] STATE_IDLE    = ENV_IDLE;
   localparam logic [2:0] STATE_ATTACK  = ENV_ATTACK;
   localparam logic [2:0] STATE_DECAY   = ENV_DECAY;
   localparam logic [2:0] STATE_SUSTAIN = ENV_SUSTAIN;
   localparam logic [2:0] STATE_RELEASE = ENV_RELEASE;

   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] ceil);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return (sum > {1'b0, ceil}) ? ceil : sum[31:0];
   endfunction

   function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] floor);
      logic [31:0] diff;
      diff = a - b;
      if (b > a) return floor;
      return (diff < floor) ? floor : diff;
   endfunction

endpackage

// File: rtl/envelope_level_gen.sv
// ADSR state machine and level register; advances only on ticks.
// ENVELOPE_EXP_RELEASE_EN selects an exponential release tail (level>>4, min 1).
module envelope_level_gen
   import envelope_pkg::*;
#(
   parameter int unsigned env_width_p     = 16,
   parameter int unsigned attack_step_p   = 16384,
   parameter int unsigned decay_step_p    = 8192,
   parameter int unsigned sustain_level_p = 32768,
   parameter int unsigned release_step_p  = 4096
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   tick,
   input  logic                   gate,
   output logic [env_width_p-1:0] level,
   output logic [2:0]             state
);

   localparam logic [env_width_p-1:0] full_c    = '1;
   localparam logic [env_width_p-1:0] sustain_c = env_width_p'(sustain_level_p);

   logic [env_width_p-1:0] level_q, level_d;
   logic [2:0]             state_q, state_d;
   logic [31:0]            rel_dec;

   always_comb begin
`ifdef ENVELOPE_EXP_RELEASE_EN
      rel_dec = 32'(level_q >> 4);
      if (rel_dec == '0) rel_dec = 32'd1;
`else
      rel_dec = 32'(release_step_p);
`endif
   end

   // Gate checks come first in each state so they win over threshold moves.
   always_comb begin
      level_d = level_q;
      state_d = state_q;
      if (tick) begin
         case (state_q)
            STATE_IDLE: begin
               if (gate) state_d = STATE_ATTACK;
            end
            STATE_ATTACK: begin
               if (!gate) begin
                  state_d = STATE_RELEASE;
               end else begin
                  level_d = env_width_p'(sat_add(32'(level_q), 32'(attack_step_p), 32'(full_c)));
                  if (level_d == full_c) state_d = STATE_DECAY;
               end
            end
            STATE_DECAY: begin
               if (!gate) begin
                  state_d = STATE_RELEASE;
               end else begin
                  level_d = env_width_p'(sat_sub(32'(level_q), 32'(decay_step_p), 32'(sustain_c)));
                  if (level_d == sustain_c) state_d = STATE_SUSTAIN;
               end
            end
            STATE_SUSTAIN: begin
               if (!gate) state_d = STATE_RELEASE;
            end
            STATE_RELEASE: begin
               if (gate) begin
                  state_d = STATE_ATTACK;
               end else begin
                  level_d = env_width_p'(sat_sub(32'(level_q), rel_dec, 32'd0));
                  if (level_d == '0) state_d = STATE_IDLE;
               end
            end
            default: begin
               state_d = STATE_IDLE;
               level_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         level_q <= '0;
         state_q <= STATE_IDLE;
      end else begin
         level_q <= level_d;
         state_q <= state_d;
      end
   end

   assign level = level_q;
   assign state = state_q;

endmodule

// File: rtl/envelope_adsr.sv
// ADSR amplitude envelope applied to a valid/ready sample stream, one output register.
// Build option ENVELOPE_EXP_RELEASE_EN switches to an exponential release tail.
module envelope_adsr
   import envelope_pkg::*;
#(
   parameter int unsigned width_p         = 12,
   parameter int unsigned env_width_p     = 16,
   parameter int unsigned attack_step_p   = 16384,
   parameter int unsigned decay_step_p    = 8192,
   parameter int unsigned sustain_level_p = 32768,
   parameter int unsigned release_step_p  = 4096
) (
   input  logic                   clk_i,
   input  logic                   reset_ni,
   input  logic                   gate_i,
   input  logic                   valid_i,
   input  logic [width_p-1:0]     data_i,
   output logic                   ready_o,
   output logic                   valid_o,
   output logic [width_p-1:0]     data_o,
   input  logic                   ready_i,
   output logic [env_width_p-1:0] env_level_o,
   output logic [2:0]             state_o
);

   logic                           valid_q;
   logic [width_p-1:0]             data_q;
   logic                           tick;
   logic [env_width_p-1:0]         level;
   logic [width_p+env_width_p-1:0] product;

   assign ready_o = ~valid_q | ready_i;
   assign tick    = valid_i & ready_o;
   // Uses the pre-update level: the level register only changes at this same edge.
   assign product = (width_p + env_width_p)'(data_i) * (width_p + env_width_p)'(level);

   envelope_level_gen #(
      .env_width_p    (env_width_p),
      .attack_step_p  (attack_step_p),
      .decay_step_p   (decay_step_p),
      .sustain_level_p(sustain_level_p),
      .release_step_p (release_step_p)
   ) u_level_gen (
      .clk    (clk_i),
      .reset_n(reset_ni),
      .tick   (tick),
      .gate   (gate_i),
      .level  (level),
      .state  (state_o)
   );

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (tick) begin
         valid_q <= 1'b1;
         data_q  <= width_p'(product >> env_width_p);
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o     = valid_q;
   assign data_o      = data_q;
   assign env_level_o = level;

endmodule
